bitty_fetch_unit: RTL and testbench
===================================

Name: bitty_fetch_unit

Overview:
- Instruction-issue front end for the bitty core, and the driver side of its run/instruction/done handshake.
- Reads a program of up to 255 16-bit instructions from a synchronous instruction memory.
- Presents each instruction to the core, pulses run, waits for done, then advances the PC.
- Sits between the instruction memory and the bitty core. Adds a start/halt interface and a done-timeout watchdog.

Parameters:
- ADDR_W, 8, instruction memory address width.
- INSTR_W, 16, instruction width. Must match the core.
- TIMEOUT_CYCLES, 64, maximum EXEC cycles allowed without done before an error is flagged.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a program run; honoured only in IDLE or ERROR.
- halt_req  in  1  request to stop after the current instruction completes.
- prog_len  in  ADDR_W  number of instructions to execute from address 0; sampled on start.
- mem_addr  out  ADDR_W  instruction memory read address.
- mem_rd_en  out  1  memory read strobe; mem_rdata is valid the following cycle.
- mem_rdata  in  INSTR_W  instruction memory read data.
- run  out  1  one-cycle pulse to the core starting execution of `instruction`.
- instruction  out  INSTR_W  instruction presented to the core.
- done  in  1  one-cycle completion pulse from the core.
- busy  out  1  high in FETCH, WAIT_MEM, ISSUE and EXEC.
- finished  out  1  one-cycle pulse when a program run ends normally.
- timeout_err  out  1  sticky watchdog error flag.
- instr_count  out  ADDR_W  instructions completed (done received) since the last start.

Behaviour:
- Reset values: all outputs are 0; state=IDLE, pc=0, halt_pending=0, watchdog=0. Reset has priority over every other input. Reset mid-operation returns to IDLE on the next edge, with run low and no pending memory read.
- IDLE, on start:
  - Latch prog_len into len_q, clear instr_count and timeout_err, set pc=0.
  - If prog_len==0: go to FINISH; no read and no run are issued.
  - Otherwise: go to FETCH.
- FETCH (1 cycle): mem_addr=pc, mem_rd_en=1. Next state is WAIT_MEM.
- WAIT_MEM (1 cycle): mem_rd_en=0. At the end of the cycle, instruction<=mem_rdata. Next state is ISSUE.
- ISSUE (1 cycle): run=1. Clear the watchdog. Next state is EXEC.
- EXEC: run=0, watchdog increments each cycle.
  - On done: instr_count++ and pc++.
    - If halt_pending, or pc+1==len_q: go to FINISH.
    - Otherwise: go to FETCH.
  - Else if watchdog==TIMEOUT_CYCLES-1: go to ERROR. This is the TIMEOUT_CYCLES-th EXEC cycle without done.
  - If done arrives on that same limit cycle, done wins.
- FINISH (1 cycle): finished=1, halt_pending cleared. Next state is IDLE.
- ERROR: timeout_err=1 (held), busy=0. Stays until start, which clears the flag and begins a new run exactly as from IDLE, or until reset.
- instruction timing:
  - Held stable from the ISSUE cycle through the end of EXEC.
  - Retains its last value in IDLE, FINISH and ERROR.
  - Changes only at the end of WAIT_MEM.
- halt_pending is set by halt_req in any busy state, including the cycle of done. An in-flight instruction is never aborted. halt_req in IDLE or ERROR is ignored.
- Ignored inputs:
  - start while busy or in FINISH.
  - done outside EXEC, including the ISSUE cycle.
- Per-instruction latency: 3+k cycles from FETCH to the next FETCH, where done arrives in the k-th EXEC cycle (k≥1).
- pc never wraps, because prog_len ≤ 2^ADDR_W−1.
- Watchdog width is clog2(TIMEOUT_CYCLES+1).

Decomposition:
- bitty_pkg holds:
  - the state enum: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, FINISH, ERROR;
  - INSTR_W;
  - the default TIMEOUT_CYCLES.
- One natural sub-module, bitty_watchdog: a clear/enable counter with a terminal-count output. The FSM, pc and instruction register stay in the top module.

Test Plan:
- prog_len=3, mem={0x1234,0x5678,0x9ABC}, done 2 cycles after each run → mem_addr 0,1,2; three run pulses carrying the three values in order; finished pulse; instr_count=3; busy low afterwards; 5 cycles per instruction.
- prog_len=0, start → no mem_rd_en, no run; finished pulses 1 cycle after start; instr_count=0.
- prog_len=5, halt_req pulsed during the 2nd EXEC → finished after the 2nd done; instr_count=2; no fetch of address 2.
- TIMEOUT_CYCLES=8, done never asserted → ERROR after 8 EXEC cycles, timeout_err=1, busy=0. Then start with prog_len=1 and a prompt done → timeout_err cleared, finished pulse. Also: done on exactly the 8th EXEC cycle → no error.
- Reset asserted during EXEC → all outputs 0 next cycle; a later done is ignored; no run until a new start.
- start pulsed mid-run and done pulsed in IDLE → no effect on pc, instr_count or state.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared types and default sizing for the bitty core instruction-issue front end.
package bitty_pkg;

   localparam int unsigned INSTR_W        = 16;
   localparam int unsigned ADDR_W         = 8;
   localparam int unsigned TIMEOUT_CYCLES = 64;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_MEM,
      ISSUE,
      EXEC,
      FINISH,
      ERROR
   } state_e;

endpackage

// File: rtl/bitty_watchdog.sv
// Clear/enable cycle counter that flags the last allowed cycle of an execution window.
module bitty_watchdog #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic at_limit_c
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   // High during the LIMIT-th enabled cycle after a clear.
   assign at_limit_c = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bitty_fetch_unit.sv
// Fetches a program from instruction memory and drives the bitty core run/done handshake,
// with start/halt control and a done-timeout watchdog.
module bitty_fetch_unit #(
   parameter int unsigned ADDR_W         = bitty_pkg::ADDR_W,
   parameter int unsigned INSTR_W        = bitty_pkg::INSTR_W,
   parameter int unsigned TIMEOUT_CYCLES = bitty_pkg::TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               halt_req,
   input  logic [ADDR_W-1:0]  prog_len,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd_en,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               run,
   output logic [INSTR_W-1:0] instruction,
   input  logic               done,
   output logic               busy,
   output logic               finished,
   output logic               timeout_err,
   output logic [ADDR_W-1:0]  instr_count
);

   import bitty_pkg::*;

   state_e             state, state_d;
   logic [ADDR_W-1:0]  pc, pc_d;
   logic [ADDR_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0]  count_d;
   logic [INSTR_W-1:0] instr_d;
   logic               halt_pending, halt_d;
   logic               wd_limit_c;
   logic               in_busy_c;

   bitty_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == ISSUE),
      .enable    (state == EXEC),
      .at_limit_c(wd_limit_c)
   );

   assign in_busy_c = (state == FETCH) || (state == WAIT_MEM) ||
                      (state == ISSUE) || (state == EXEC);

   // Next-state, pc, length, halt and count logic.
   always_comb begin
      state_d = state;
      pc_d    = pc;
      len_d   = len_q;
      halt_d  = halt_pending;
      count_d = instr_count;
      instr_d = instruction;

      case (state)
         IDLE, ERROR: begin
            if (start) begin
               len_d   = prog_len;
               count_d = '0;
               pc_d    = '0;
               halt_d  = 1'b0;
               state_d = (prog_len == '0) ? FINISH : FETCH;
            end
         end
         FETCH:    state_d = WAIT_MEM;
         WAIT_MEM: begin
            instr_d = mem_rdata;
            state_d = ISSUE;
         end
         ISSUE:    state_d = EXEC;
         EXEC: begin
            // done beats the watchdog when both land on the same cycle
            if (done) begin
               count_d = instr_count + ADDR_W'(1);
               pc_d    = pc + ADDR_W'(1);
               state_d = (halt_pending || halt_req || (pc_d == len_q)) ? FINISH : FETCH;
            end else if (wd_limit_c) begin
               state_d = ERROR;
            end
         end
         FINISH: begin
            halt_d  = 1'b0;
            state_d = IDLE;
         end
         default:  state_d = IDLE;
      endcase

      if (in_busy_c && halt_req && (state_d != FINISH)) begin
         halt_d = 1'b1;
      end
   end

   // State register; outputs are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= '0;
         len_q        <= '0;
         halt_pending <= 1'b0;
         mem_addr     <= '0;
         mem_rd_en    <= 1'b0;
         run          <= 1'b0;
         instruction  <= '0;
         busy         <= 1'b0;
         finished     <= 1'b0;
         timeout_err  <= 1'b0;
         instr_count  <= '0;
      end else begin
         state        <= state_d;
         pc           <= pc_d;
         len_q        <= len_d;
         halt_pending <= halt_d;
         instruction  <= instr_d;
         instr_count  <= count_d;
         mem_rd_en    <= (state_d == FETCH);
         if (state_d == FETCH) begin
            mem_addr <= pc_d;
         end
         run          <= (state_d == ISSUE);
         busy         <= (state_d == FETCH) || (state_d == WAIT_MEM) ||
                         (state_d == ISSUE) || (state_d == EXEC);
         finished     <= (state_d == FINISH);
         timeout_err  <= (state_d == ERROR);
      end
   end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Randomized bench for bitty_fetch_unit: memory and core models driven cycle by cycle,
// outcomes compared with a timing model derived from per-instruction done latencies.
module tb_bitty_fetch_unit;

   localparam int unsigned AW = 8;
   localparam int unsigned IW = 16;
   localparam int          T  = 8;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          start     = 1'b0;
   logic          halt_req  = 1'b0;
   logic [AW-1:0] prog_len  = '0;
   logic [IW-1:0] mem_rdata = '0;
   logic          done      = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic          run;
   logic [IW-1:0] instruction;
   logic          busy;
   logic          finished;
   logic          timeout_err;
   logic [AW-1:0] instr_count;

   logic [IW-1:0] mem [256];
   int            k   [256];   // done latency in EXEC cycles per instruction; 0 = never
   int            n_tests = 0;
   int            n_fail  = 0;

   bitty_fetch_unit #(
      .ADDR_W(AW), .INSTR_W(IW), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .prog_len(prog_len),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .run(run),
      .instruction(instruction), .done(done), .busy(busy), .finished(finished),
      .timeout_err(timeout_err), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mem_addr"},    32'(mem_addr),    0);
      check({tag, "_mem_rd_en"},   32'(mem_rd_en),   0);
      check({tag, "_run"},         32'(run),         0);
      check({tag, "_instruction"}, 32'(instruction), 0);
      check({tag, "_busy"},        32'(busy),        0);
      check({tag, "_finished"},    32'(finished),    0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 0);
      check({tag, "_instr_count"}, 32'(instr_count), 0);
   endtask

   // Cycle 1 is the first cycle after the start edge. Each instruction spans 3 + k cycles
   // from its fetch; a missing done ends the run after T EXEC cycles instead.
   function automatic void model(input int len, input int halt_at, output int n_fetch,
                                 output int n_done, output int end_cyc, output bit err);
      int f;
      f       = 1;
      n_fetch = 0;
      n_done  = 0;
      end_cyc = 1;
      err     = 1'b0;
      for (int i = 0; i < len; i++) begin
         n_fetch++;
         if (k[i] == 0) begin
            err     = 1'b1;
            end_cyc = f + 3 + T;
            return;
         end
         n_done++;
         end_cyc = f + 3 + k[i];
         if (i == halt_at) return;
         f = f + 3 + k[i];
      end
   endfunction

   task automatic run_prog(input int len, input int halt_at);
      int fi, ri, cd, hcd, end_obs, budget;
      int exp_fetch, exp_done, exp_end;
      bit exp_err;
      model(len, halt_at, exp_fetch, exp_done, exp_end, exp_err);
      budget  = len * (3 + T) + 10;
      fi      = 0;
      ri      = 0;
      cd      = 0;
      hcd     = 0;
      end_obs = -1;
      @(negedge clk);
      prog_len = AW'(len);
      start    = 1'b1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         start    = 1'b0;
         done     = 1'b0;
         halt_req = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) done = 1'b1;
         end
         if (hcd > 0) begin
            hcd--;
            if (hcd == 0) halt_req = 1'b1;
         end
         if (mem_rd_en) begin
            check("fetch_addr", 32'(mem_addr), 32'(fi));
            mem_rdata = mem[mem_addr];
            fi++;
            // stray done and start while busy must be ignored
            if ($urandom_range(1) == 1) done = 1'b1;
            if ($urandom_range(1) == 1) start = 1'b1;
         end
         if (run) begin
            check("busy_issue", 32'(busy), 1);
            if (ri < 256) begin
               check("run_instr", 32'(instruction), 32'(mem[ri]));
               cd = k[ri];
            end
            if (ri == halt_at) hcd = 1;
            ri++;
         end
         if (finished || timeout_err) begin
            end_obs = cyc;
            break;
         end
      end
      done     = 1'b0;
      halt_req = 1'b0;
      start    = 1'b0;
      check("end_cycle",   32'(end_obs),     32'(exp_end));
      check("fetches",     32'(fi),          32'(exp_fetch));
      check("runs",        32'(ri),          32'(exp_fetch));
      check("instr_count", 32'(instr_count), 32'(exp_done));
      check("timeout_err", 32'(timeout_err), 32'(exp_err));
      check("busy_end",    32'(busy),        0);
      if (end_obs >= 0) begin
         @(negedge clk);
         if (exp_err) check("err_sticky", 32'(timeout_err), 1);
         else         check("finished_pulse", 32'(finished), 0);
         check("busy_after", 32'(busy), 0);
      end
   endtask

   // halt_req and done while idle or in error must change nothing.
   task automatic idle_noise();
      logic [AW-1:0] cnt_before;
      cnt_before = instr_count;
      @(negedge clk);
      halt_req = 1'b1;
      done     = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      done     = 1'b0;
      check("idle_count", 32'(instr_count), 32'(cnt_before));
      check("idle_busy",  32'(busy),        0);
   endtask

   task automatic reset_test();
      bit seen;
      k[0] = 0;
      @(negedge clk);
      prog_len = AW'(3);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !run; i++) @(negedge clk);
      check("rst_run_seen", 32'(run), 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_zero("mid_reset");
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (run || mem_rd_en || busy) seen = 1'b1;
      end
      check("post_reset_quiet", 32'(seen),        0);
      check("post_reset_count", 32'(instr_count), 0);
   endtask

   initial begin
      int len, halt_at;
      for (int i = 0; i < 256; i++) begin
         mem[i] = IW'($urandom);
         k[i]   = 1;
      end
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      mem[0] = 16'h1234;
      mem[1] = 16'h5678;
      mem[2] = 16'h9ABC;
      k[0] = 2; k[1] = 2; k[2] = 2;
      run_prog(3, -1);
      idle_noise();
      run_prog(0, -1);

      for (int i = 0; i < 5; i++) k[i] = int'($urandom_range(T, 1));
      run_prog(5, 1);

      k[0] = 0;
      run_prog(2, -1);
      idle_noise();
      k[0] = 1;
      run_prog(1, -1);
      k[0] = T;
      k[1] = T;
      run_prog(2, -1);

      reset_test();

      for (int r = 0; r < 14; r++) begin
         len = int'($urandom_range(6, 1));
         for (int i = 0; i < len; i++)
            k[i] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(T, 1));
         halt_at = ($urandom_range(2) == 0) ? int'($urandom_range(len - 1)) : -1;
         for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
         run_prog(len, halt_at);
         idle_noise();
      end

      for (int i = 0; i < 256; i++) k[i] = 1;
      run_prog(255, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
